first_counter_checker: RTL and testbench

//   Receive-side monitor for the free-running first_counter.

---
 rtl/first_counter_checker_pkg.sv | 14 +
 rtl/first_counter_checker_sat_counter.sv | 27 ++
 rtl/first_counter_checker.sv | 121 ++++++++++++
 tb/tb_first_counter_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/first_counter_checker_pkg.sv
// Shared definitions for the first_counter checker: checker state encodings and
// default bus widths common with the observed first_counter.
package first_counter_checker_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_UNSYNC = 2'd0;
    localparam state_t ST_SYNC   = 2'd1;
    localparam state_t ST_FAULT  = 2'd2;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/first_counter_checker_sat_counter.sv
// Saturating statistics counter: holds at all-ones, clr has priority over inc.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_r;

    // Count register with synchronous clear and saturation at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_r <= '0;
        end else if (clr) begin
            value_r <= '0;
        end else if (inc && (value_r != {CNT_W{1'b1}})) begin
            value_r <= value_r + CNT_W'(1);
        end
    end

    assign value = value_r;

endmodule

// File: rtl/first_counter_checker.sv
// Passive monitor for first_counter: predicts each next sample, flags mismatches
// and keeps saturating mismatch / wrap statistics.
module first_counter_checker
    import first_counter_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STICKY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dut_reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic             fault,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    state_t           state_r;
    state_t           fsm_next_s;
    state_t           state_next_s;
    logic [WIDTH-1:0] expected_r;
    logic [WIDTH-1:0] model_s;
    logic             mismatch_s;
    logic             wrap_s;
    logic             error_r;
    logic             locked_r;
    logic             fault_r;

    // Reference model of the observed counter; dut_reset beats enable.
    always_comb begin
        model_s = count_in;
        if (dut_reset) begin
            model_s = '0;
        end else if (enable) begin
            model_s = count_in + WIDTH'(1);
        end else begin
            model_s = count_in;
        end
    end

    // Comparison, wrap detection and state transitions; clear overrides all.
    always_comb begin
        mismatch_s = 1'b0;
        wrap_s     = 1'b0;
        fsm_next_s = state_r;
        case (state_r)
            ST_UNSYNC: begin
                if (dut_reset) begin
                    fsm_next_s = ST_SYNC;
                end else begin
                    fsm_next_s = ST_UNSYNC;
                end
            end
            ST_SYNC: begin
                mismatch_s = (count_in != expected_r);
                wrap_s     = (count_in == {WIDTH{1'b1}}) && enable && !dut_reset;
                if (mismatch_s && (STICKY != 0)) begin
                    fsm_next_s = ST_FAULT;
                end else begin
                    fsm_next_s = ST_SYNC;
                end
            end
            ST_FAULT: begin
                fsm_next_s = ST_FAULT;
            end
            default: begin
                fsm_next_s = ST_UNSYNC;
            end
        endcase
        if (clear) begin
            state_next_s = ST_UNSYNC;
        end else begin
            state_next_s = fsm_next_s;
        end
    end

    // State, prediction and registered status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_UNSYNC;
            expected_r <= '0;
            error_r    <= 1'b0;
            locked_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            expected_r <= model_s;
            error_r    <= mismatch_s && !clear;
            locked_r   <= (state_next_s == ST_SYNC);
            fault_r    <= (state_next_s == ST_FAULT);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_count (
        .clock (clock),
        .reset (reset),
        .inc   (mismatch_s),
        .clr   (clear),
        .value (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_count (
        .clock (clock),
        .reset (reset),
        .inc   (wrap_s),
        .clr   (clear),
        .value (wrap_count)
    );

    assign locked   = locked_r;
    assign error    = error_r;
    assign fault    = fault_r;
    assign expected = expected_r;

endmodule

// File: tb/tb_first_counter_checker.sv
// Bench: two checkers (sticky/8-bit stats and resyncing/2-bit stats) watch a
// bench-driven counter; outputs are compared every cycle against a behavioural model.
module tb_first_counter_checker;

    localparam int MODN = 16;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       dut_reset = 1'b0;
    logic       enable    = 1'b0;
    logic       clear     = 1'b0;
    logic [3:0] count_in  = 4'd0;

    logic       locked0, error0, fault0;
    logic [3:0] expected0;
    logic [7:0] errc0, wrapc0;
    logic       locked1, error1, fault1;
    logic [3:0] expected1;
    logic [1:0] errc1, wrapc1;

    first_counter_checker #(.WIDTH(4), .CNT_W(8), .STICKY(1)) u_dut_sticky (
        .clock(clock), .reset(reset), .dut_reset(dut_reset), .enable(enable),
        .count_in(count_in), .clear(clear), .locked(locked0), .error(error0),
        .fault(fault0), .expected(expected0), .err_count(errc0), .wrap_count(wrapc0)
    );

    first_counter_checker #(.WIDTH(4), .CNT_W(2), .STICKY(0)) u_dut_resync (
        .clock(clock), .reset(reset), .dut_reset(dut_reset), .enable(enable),
        .count_in(count_in), .clear(clear), .locked(locked1), .error(error1),
        .fault(fault1), .expected(expected1), .err_count(errc1), .wrap_count(wrapc1)
    );

    always #5 clock = ~clock;

    // mode: 0 = not yet synchronised, 1 = checking, 2 = latched fault
    typedef struct {
        int mode;
        int exp_v;
        int errc;
        int wrapc;
        bit err;
    } mdl_t;

    mdl_t m0, m1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   cnt    = 0;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.mode = 0; z.exp_v = 0; z.errc = 0; z.wrapc = 0; z.err = 1'b0;
        return z;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit rst, bit dr, bit en, int cin,
                                      bit clr, bit sticky, int cmax);
        mdl_t n;
        if (!rst) return mdl_zero();
        n = m;
        n.err = 1'b0;
        n.exp_v = dr ? 0 : (en ? (cin + 1) % MODN : cin);
        if (clr) begin
            n.mode = 0; n.errc = 0; n.wrapc = 0;
            return n;
        end
        if (m.mode == 0) begin
            if (dr) n.mode = 1;
        end else if (m.mode == 1) begin
            if (cin != m.exp_v) begin
                n.err  = 1'b1;
                n.errc = (m.errc < cmax) ? m.errc + 1 : cmax;
                if (sticky) n.mode = 2;
            end
            if (cin == MODN - 1 && en && !dr)
                n.wrapc = (m.wrapc < cmax) ? m.wrapc + 1 : cmax;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both checkers against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("locked0",   locked0,   m0.mode == 1);
            chk("fault0",    fault0,    m0.mode == 2);
            chk("error0",    error0,    m0.err);
            chk("expected0", expected0, m0.exp_v);
            chk("errc0",     errc0,     m0.errc);
            chk("wrapc0",    wrapc0,    m0.wrapc);
            chk("locked1",   locked1,   m1.mode == 1);
            chk("fault1",    fault1,    m1.mode == 2);
            chk("error1",    error1,    m1.err);
            chk("expected1", expected1, m1.exp_v);
            chk("errc1",     errc1,     m1.errc);
            chk("wrapc1",    wrapc1,    m1.wrapc);
        end
    end

    // One clock of the observed counter; jump makes the counter skip a value.
    task automatic step(input bit rst, input bit dr, input bit en, input bit clr, input bit jump);
        #1;
        if (jump) cnt = (cnt + 1) % MODN;
        reset     = rst;
        dut_reset = dr;
        enable    = en;
        clear     = clr;
        count_in  = cnt[3:0];
        @(posedge clock);
        m0  = mdl_next(m0, rst, dr, en, cnt, clr, 1'b1, 255);
        m1  = mdl_next(m1, rst, dr, en, cnt, clr, 1'b0, 3);
        cnt = dr ? 0 : (en ? (cnt + 1) % MODN : cnt);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        m0 = mdl_zero();
        m1 = mdl_zero();
        chk_en = 1'b1;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_locked0", locked0, 1'b0);
        chk("rst_expected0", expected0, 4'd0);
        chk("rst_errc1", errc1, 2'd0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lock_after_dut_reset", locked0, 1'b1);
        repeat (20) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap0_once", wrapc0, 8'd1);
        chk("wrap1_once", wrapc1, 2'd1);
        chk("no_err0", errc0, 8'd0);

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sticky_error_pulse", error0, 1'b1);
        chk("sticky_errc", errc0, 8'd1);
        chk("sticky_fault", fault0, 1'b1);
        chk("sticky_unlocked", locked0, 1'b0);
        chk("resync_errc", errc1, 2'd1);
        chk("resync_locked", locked1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("resync_pulse_end", error1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 1) begin
                chk("resync_three_errs", errc1, 2'd3);
                chk("resync_still_locked", locked1, 1'b1);
            end
        end
        chk("resync_errc_saturated", errc1, 2'd3);
        chk("fault_freezes_errc", errc0, 8'd1);

        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clear_fault", fault0, 1'b0);
        chk("clear_unlocked", locked0, 1'b0);
        chk("clear_errc0", errc0, 8'd0);
        chk("clear_wrapc0", wrapc0, 8'd0);

        cnt = 9;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_beats_enable", expected0, 4'd0);
        chk("relock", locked0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_after_reset_ok", error0, 1'b0);

        repeat (64) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap0_four", wrapc0, 8'd4);
        chk("wrap1_saturated", wrapc1, 2'd3);

        repeat (400) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 47) == 0,
                 $urandom_range(0, 23) == 0);
        end

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("locked_before_midreset", locked0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("midreset_locked0", locked0, 1'b0);
        chk("midreset_expected0", expected0, 4'd0);
        chk("midreset_wrapc0", wrapc0, 8'd0);
        chk("midreset_locked1", locked1, 1'b0);
        chk("midreset_expected1", expected1, 4'd0);
        chk("midreset_wrapc1", wrapc1, 2'd0);
        m0 = mdl_zero();
        m1 = mdl_zero();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("no_compare_before_dut_reset", errc0, 8'd0);
        chk("unsync_after_reset", locked0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
